// File: rtl/kt4_result_fifo.sv
// Result FIFO behind the kt4 stage: captures valid-only strobes into a circular
// buffer and re-presents them as a first-word-fall-through valid/ready stream with frame markers.
module kt4_result_fifo #(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 16,
    parameter int FRAME_LEN    = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          kt4_result,
    input  logic                       kt4_result_vld,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
    localparam logic [FW-1:0] FLAST_C = FW'(FRAME_LEN - 1);

    // Each entry carries its end-of-frame marker alongside the data.
    logic [DATA_W:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [FW-1:0]     r_frame_cnt;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_drop;
    logic [DATA_W:0]   w_head;

    assign m_tvalid    = (r_count != '0);
    assign w_full      = (r_count == FULL_C);
    assign w_pop       = m_tvalid & m_tready;
    // A pop on a full FIFO frees the slot for a strobe arriving in the same cycle.
    assign w_push      = kt4_result_vld & (~w_full | w_pop);
    assign w_drop      = kt4_result_vld & w_full & ~w_pop;
    assign w_head      = r_mem[r_rd_ptr];

    assign m_tdata     = m_tvalid ? w_head[DATA_W-1:0] : '0;
    assign m_tlast     = m_tvalid & w_head[DATA_W];
    assign count       = r_count;
    assign almost_full = (r_count >= AFULL_C);
    assign overflow    = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= {(r_frame_cnt == FLAST_C), kt4_result};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + AW'(1);
                r_frame_cnt <= (r_frame_cnt == FLAST_C) ? '0 : r_frame_cnt + FW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Set has priority over clear so a drop in the clear cycle is not lost.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kt4_result_fifo.sv
// Bench for kt4_result_fifo: directed table, hand sequences and random traffic,
// all checked against a queue-based reference of the FIFO behaviour.
module tb_kt4_result_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] kt4_result;
    logic        kt4_result_vld;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [4:0]  count;
    logic        almost_full;
    logic        overflow;
    logic        clr_overflow;

    int n_vec = 0;
    int n_err = 0;

    kt4_result_fifo dut (
        .clk(clk), .rst(rst), .kt4_result(kt4_result), .kt4_result_vld(kt4_result_vld),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .count(count), .almost_full(almost_full), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // Reference: queue of {last, data}, accepted-result counter, sticky flag.
    logic [64:0] mq[$];
    int          fpos;
    bit          movf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [64:0] head;
        head = (mq.size() != 0) ? mq[0] : 65'd0;
        chk("m_tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
        chk("m_tdata", m_tdata, head[63:0]);
        chk("m_tlast", 64'(m_tlast), 64'(head[64]));
        chk("count", 64'(count), 64'(mq.size()));
        chk("almost_full", 64'(almost_full), 64'(mq.size() >= 12));
        chk("overflow", 64'(overflow), 64'(movf));
    endtask

    // Apply one cycle of inputs, advance the reference, compare #1 after the edge.
    task automatic step(input bit vld, input logic [63:0] d, input bit rdy,
                        input bit clr, input bit r);
        bit pop, push, drop;
        kt4_result = d; kt4_result_vld = vld; m_tready = rdy;
        clr_overflow = clr; rst = r;
        pop  = (mq.size() != 0) && rdy;
        push = vld && ((mq.size() < 16) || pop);
        drop = vld && (mq.size() == 16) && !pop;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            fpos = 0;
            movf = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({(fpos % 8) == 7, d});
                fpos++;
            end
            if (drop) movf = 1;
            else if (clr) movf = 0;
        end
        check_model();
    endtask

    typedef struct {
        bit          rst;
        bit          vld;
        logic [63:0] data;
        bit          rdy;
        bit          exp_valid;
        logic [63:0] exp_data;
        int          exp_count;
    } vec_t;

    vec_t tbl[6];

    initial begin
        rst = 1'b1; kt4_result = '0; kt4_result_vld = 1'b0; m_tready = 1'b0; clr_overflow = 1'b0;
        fpos = 0; movf = 0;

        // Reset with random inputs, then order/latency with m_tready=1.
        tbl[0] = '{1, 1'($urandom), {$urandom, $urandom}, 1'($urandom), 0, 64'h0, 0};
        tbl[1] = '{1, 1'($urandom), {$urandom, $urandom}, 1'($urandom), 0, 64'h0, 0};
        tbl[2] = '{0, 1, 64'h3FF0_0000_0000_0000, 1, 1, 64'h3FF0_0000_0000_0000, 1};
        tbl[3] = '{0, 1, 64'h4000_0000_0000_0000, 1, 1, 64'h4000_0000_0000_0000, 1};
        tbl[4] = '{0, 1, 64'h4008_0000_0000_0000, 1, 1, 64'h4008_0000_0000_0000, 1};
        tbl[5] = '{0, 0, 64'h0,                   1, 0, 64'h0,                   0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].vld, tbl[i].data, tbl[i].rdy, 1'b0, tbl[i].rst);
            chk("tbl_valid", 64'(m_tvalid), 64'(tbl[i].exp_valid));
            chk("tbl_data", m_tdata, tbl[i].exp_data);
            chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
            chk("tbl_overflow", 64'(overflow), 64'd0);
        end

        // Fill to full with m_tready=0, 17th strobe dropped.
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_count", 64'(count), 64'((i <= 16) ? i : 16));
            chk("fill_afull", 64'(almost_full), 64'(i >= 12));
            chk("fill_ovf", 64'(overflow), 64'(i == 17));
        end
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        for (int k = 1; k <= 16; k++) begin
            chk("drain_data", m_tdata, 64'(k));
            step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 64'(m_tvalid), 64'd0);
        chk("ovf_before_clr", 64'(overflow), 64'd1);
        step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) step(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hAA, 1'b1, 1'b0, 1'b0);
        chk("pp_count", 64'(count), 64'd16);
        chk("pp_ovf", 64'(overflow), 64'd0);
        for (int k = 0; k < 16; k++) begin
            chk("pp_order", m_tdata, (k == 15) ? 64'hAA : 64'h101 + 64'(k));
            step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        end

        // Framing: 16 accepted results from frame position 0.
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk("frame_last", 64'(m_tlast), 64'(k == 7 || k == 15));
            step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        end

        // Framing with a dropped strobe after 5 accepted in a frame.
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 64'h300 + 64'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 64'h400 + 64'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
        chk("fdrop_ovf", 64'(overflow), 64'd1);
        for (int k = 0; k < 16; k++) begin
            chk("fdrop_last_a", 64'(m_tlast), 64'(((k + 5) % 8) == 7));
            step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 64'h500 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("fdrop_last_b", 64'(m_tlast), 64'(k == 2));
            step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        end

        // Wrap with random m_tready gaps, then reset with 5 stored.
        step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++)
            step(1'b1, 64'h600 + 64'(i), ($urandom % 4) != 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 64'h700 + 64'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd5);
        step(1'b1, 64'h777, 1'b1, 1'b0, 1'b1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 64'h800 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("post_rst_last", 64'(m_tlast), 64'(k == 7));
            step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        end

        // Fully random traffic including clears and occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom % 3) != 0, {$urandom, $urandom}, 1'($urandom),
                 ($urandom % 16) == 0, ($urandom % 64) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
